// File: rtl/mem_access_stage_if.sv
// ============================================================================
// mem_access_stage_if : core-side request and bus-side signals of the MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic [15:0] MemRData;
  logic        Stall;
  logic        MemDone;
  logic        MemErr;
  logic [15:0] BusAddr;
  logic [15:0] BusWData;
  logic        BusRE;
  logic        BusWE;
  logic        BusReady;
  logic [15:0] BusRData;

  // The stage masters the bus on behalf of the core.
  modport master (
    input  MemRead, MemWrite, MemAddr, MemWData, BusReady, BusRData,
    output MemRData, Stall, MemDone, MemErr, BusAddr, BusWData, BusRE, BusWE
  );

  modport slave (
    output MemRead, MemWrite, MemAddr, MemWData, BusReady, BusRData,
    input  MemRData, Stall, MemDone, MemErr, BusAddr, BusWData, BusRE, BusWE
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : pipeline MEM stage, one bus access per request, timeout abort
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mem_access_stage_if.master  mem
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  // Last WAIT cycle before abort: the increment here would make the count reach TIMEOUT.
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;
  logic            w_conflict;
  logic            w_complete;
  logic            w_timeout;
  logic            w_stall;

  logic [CW-1:0]   r_wait_cnt;
  logic [15:0]     r_bus_addr;
  logic [15:0]     r_bus_wdata;
  logic            r_bus_re;
  logic            r_bus_we;
  logic [15:0]     r_mem_rdata;
  logic            r_mem_done;
  logic            r_mem_err;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_conflict  = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = mem.MemRead | mem.MemWrite;
        if (mem.MemRead ^ mem.MemWrite) begin
          w_start     = 1'b1;
          w_state_nxt = WAIT;
        end else if (mem.MemRead && mem.MemWrite) begin
          w_conflict  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        // BusReady takes priority over an expiring timeout.
        if (mem.BusReady) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_wait_cnt == C_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_re    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_done  <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_mem_done <= (w_state_nxt == DONE);
      if (w_start) begin
        r_bus_addr  <= mem.MemAddr;
        r_bus_wdata <= mem.MemWData;
        r_bus_re    <= mem.MemRead;
        r_bus_we    <= mem.MemWrite;
        r_wait_cnt  <= '0;
      end
      if (w_conflict) begin
        r_mem_err <= 1'b1;
      end
      // The held read strobe doubles as the latched access type.
      if (w_complete) begin
        r_bus_re <= 1'b0;
        r_bus_we <= 1'b0;
        if (r_bus_re) begin
          r_mem_rdata <= mem.BusRData;
        end
      end else if (w_timeout) begin
        r_bus_re  <= 1'b0;
        r_bus_we  <= 1'b0;
        r_mem_err <= 1'b1;
        if (r_bus_re) begin
          r_mem_rdata <= 16'hFFFF;
        end
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign mem.Stall    = rst_n & w_stall;
  assign mem.MemDone  = r_mem_done;
  assign mem.MemErr   = r_mem_err;
  assign mem.MemRData = r_mem_rdata;
  assign mem.BusAddr  = r_bus_addr;
  assign mem.BusWData = r_bus_wdata;
  assign mem.BusRE    = r_bus_re;
  assign mem.BusWE    = r_bus_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed vectors for mem_access_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the active edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata);
    mif.MemRead  = rd;
    mif.MemWrite = wr;
    mif.MemAddr  = addr;
    mif.MemWData = wdata;
  endtask

  task automatic set_bus(input logic rdy, input logic [15:0] rdata);
    mif.BusReady = rdy;
    mif.BusRData = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=%h exp=%h", 16'h0, 16'h1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_req(1'b1, 1'b0, 16'h0000, 16'h0000);
    set_bus(1'b0, 16'h0000);

    // Reset: Stall forced low even with a request present
    next_cycle();
    next_cycle();
    sample();
    check("rst_stall", mif.Stall, 1'b0);
    check("rst_re", mif.BusRE, 1'b0);
    check("rst_done", mif.MemDone, 1'b0);
    check("rst_err", mif.MemErr, 1'b0);
    check("rst_rdata", mif.MemRData, 16'h0000);
    check("rst_addr", mif.BusAddr, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    next_cycle();

    // Read, ready in first WAIT cycle
    next_cycle();
    set_req(1'b1, 1'b0, 16'h0040, 16'h0000);
    sample();
    check("a_c0_stall", mif.Stall, 1'b1);
    check("a_c0_re", mif.BusRE, 1'b0);
    next_cycle();
    set_bus(1'b1, 16'hBEEF);
    sample();
    check("a_c1_re", mif.BusRE, 1'b1);
    check("a_c1_addr", mif.BusAddr, 16'h0040);
    check("a_c1_stall", mif.Stall, 1'b1);
    check("a_c1_done", mif.MemDone, 1'b0);
    next_cycle();
    set_bus(1'b0, 16'h0000);
    sample();
    check("a_c2_done", mif.MemDone, 1'b1);
    check("a_c2_re", mif.BusRE, 1'b0);
    check("a_c2_stall", mif.Stall, 1'b0);
    check("a_c2_rdata", mif.MemRData, 16'hBEEF);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("a_c3_done", mif.MemDone, 1'b0);
    check("a_c3_re", mif.BusRE, 1'b0);

    // Write, ready after 3 wait cycles
    next_cycle();
    set_req(1'b0, 1'b1, 16'h0012, 16'h1234);
    sample();
    check("b_c0_stall", mif.Stall, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      set_bus(i == 4, 16'h7777);
      sample();
      check($sformatf("b_c%0d_we", i), mif.BusWE, 1'b1);
      check($sformatf("b_c%0d_addr", i), mif.BusAddr, 16'h0012);
      check($sformatf("b_c%0d_wdata", i), mif.BusWData, 16'h1234);
      check($sformatf("b_c%0d_done", i), mif.MemDone, 1'b0);
    end
    next_cycle();
    set_bus(1'b0, 16'h0000);
    sample();
    check("b_c5_done", mif.MemDone, 1'b1);
    check("b_c5_we", mif.BusWE, 1'b0);
    check("b_c5_rdata", mif.MemRData, 16'hBEEF);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_bus(1'b1, 16'h1111);
    sample();
    check("b_c6_done", mif.MemDone, 1'b0);
    next_cycle();
    set_bus(1'b0, 16'h0000);
    sample();
    check("idle_rdy_rdata", mif.MemRData, 16'hBEEF);
    check("idle_rdy_done", mif.MemDone, 1'b0);

    // Ready arrives in the last WAIT cycle before timeout
    next_cycle();
    set_req(1'b1, 1'b0, 16'h0200, 16'h0000);
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      set_bus(i == 15, 16'h5A5A);
      sample();
      check($sformatf("d_c%0d_re", i), mif.BusRE, 1'b1);
    end
    next_cycle();
    set_bus(1'b0, 16'h0000);
    sample();
    check("d_done", mif.MemDone, 1'b1);
    check("d_err", mif.MemErr, 1'b0);
    check("d_rdata", mif.MemRData, 16'h5A5A);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset in the middle of a read's WAIT
    next_cycle();
    set_req(1'b1, 1'b0, 16'h0300, 16'h0000);
    next_cycle();
    sample();
    check("e_c1_re", mif.BusRE, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    sample();
    check("e_rst_stall", mif.Stall, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("e_re", mif.BusRE, 1'b0);
    check("e_done", mif.MemDone, 1'b0);
    check("e_rdata", mif.MemRData, 16'h0000);
    check("e_addr", mif.BusAddr, 16'h0000);
    next_cycle();
    set_req(1'b1, 1'b0, 16'h0304, 16'h0000);
    next_cycle();
    set_bus(1'b1, 16'hCAFE);
    sample();
    check("e2_re", mif.BusRE, 1'b1);
    check("e2_addr", mif.BusAddr, 16'h0304);
    next_cycle();
    set_bus(1'b0, 16'h0000);
    sample();
    check("e2_done", mif.MemDone, 1'b1);
    check("e2_rdata", mif.MemRData, 16'hCAFE);
    check("e2_err", mif.MemErr, 1'b0);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Read timeout with BusReady never asserted
    next_cycle();
    set_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      sample();
      check($sformatf("c_c%0d_re", i), mif.BusRE, 1'b1);
      check($sformatf("c_c%0d_done", i), mif.MemDone, 1'b0);
    end
    next_cycle();
    sample();
    check("c_re", mif.BusRE, 1'b0);
    check("c_done", mif.MemDone, 1'b1);
    check("c_err", mif.MemErr, 1'b1);
    check("c_rdata", mif.MemRData, 16'hFFFF);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("c_done_off", mif.MemDone, 1'b0);
    next_cycle();
    sample();
    check("c_err_sticky", mif.MemErr, 1'b1);

    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    sample();
    check("f_rst_err", mif.MemErr, 1'b0);

    // Conflicting read and write requests
    next_cycle();
    set_req(1'b1, 1'b1, 16'h0400, 16'h9999);
    set_bus(1'b0, 16'hFFFF);
    sample();
    check("f_c0_stall", mif.Stall, 1'b1);
    check("f_c0_err", mif.MemErr, 1'b0);
    next_cycle();
    sample();
    check("f_c1_done", mif.MemDone, 1'b1);
    check("f_c1_err", mif.MemErr, 1'b1);
    check("f_c1_re", mif.BusRE, 1'b0);
    check("f_c1_we", mif.BusWE, 1'b0);
    check("f_c1_addr", mif.BusAddr, 16'h0000);
    check("f_c1_rdata", mif.MemRData, 16'h0000);
    check("f_c1_stall", mif.Stall, 1'b0);
    next_cycle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    sample();
    check("f_c2_done", mif.MemDone, 1'b0);
    check("f_c2_err", mif.MemErr, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of WAIT cycles without BusReady before the access is aborted.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 MemRead  input  1  load request from control; held stable by the core while Stall=1.
REQ-005 MemWrite  input  1  store request from control; held stable by the core while Stall=1.
REQ-006 MemAddr  input  16  effective address, taken directly from ALUout.
REQ-007 MemWData  input  16  store data.
REQ-008 MemRData  output  16  load result, registered.
REQ-009 Stall  output  1  freezes the PC and pipeline write-enables.
REQ-010 MemDone  output  1  one-cycle pulse marking access completion.
REQ-011 MemErr  output  1  sticky error flag.
REQ-012 BusAddr  output  16  registered bus address.
REQ-013 BusWData  output  16  registered bus write data.
REQ-014 BusRE  output  1  registered bus read strobe.
REQ-015 BusWE  output  1  registered bus write strobe.
REQ-016 BusReady  input  1  bus completion, sampled on the rising edge.
REQ-017 BusRData  input  16  bus read data, valid when BusReady=1.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, WAIT and DONE, with IDLE as the reset state.
REQ-019 In IDLE with exactly one of MemRead or MemWrite high, the block SHALL latch MemAddr, MemWData and the access type, drive BusAddr, BusWData and the matching strobe on the next edge, and go to WAIT.
REQ-020 In IDLE with MemRead and MemWrite both high, the block SHALL make no bus access, SHALL set MemErr, SHALL pulse MemDone on the next cycle through DONE, and SHALL leave MemRData unchanged.
REQ-021 Stall SHALL be combinational: 1 when (IDLE and any request) or state is WAIT; 0 in DONE and in IDLE with no request.
REQ-022 In WAIT the block SHALL hold the strobe, BusAddr and BusWData constant until BusReady is sampled high or the timeout occurs.
REQ-023 On the edge where BusReady=1 in WAIT, the block SHALL drop the strobe, capture BusRData into MemRData (read accesses only), and go to DONE.
REQ-024 A 4-bit-minimum wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without BusReady.
REQ-025 When the wait counter reaches TIMEOUT with BusReady still 0, the block SHALL drop the strobe, set MemErr, load MemRData with 16'hFFFF for reads, and go to DONE.
REQ-026 If BusReady=1 in the same cycle the timeout is reached, the block SHALL treat the access as a normal completion (BusReady wins).
REQ-027 In DONE, MemDone SHALL be 1 for exactly that cycle, requests SHALL be ignored, and the next state SHALL be IDLE.
REQ-028 Latency SHALL be request cycle 0, strobe in cycles 1..k, BusReady sampled in cycle k, MemDone in cycle k+1; minimum latency is 2 cycles.
REQ-029 BusReady while not in WAIT SHALL be ignored.
REQ-030 MemErr SHALL clear only on reset.

Reset
REQ-031 With rst_n low at an edge, the block SHALL return to IDLE; clear BusRE, BusWE, MemDone and MemErr; clear MemRData, BusAddr, BusWData and the wait counter to 0; and abort any in-flight access without a MemDone pulse.
REQ-032 Stall SHALL be 0 while rst_n is low.

Verification
REQ-033 Read, MemAddr=16'h0040, BusReady high in the first WAIT cycle, BusRData=16'hBEEF -> BusRE for 1 cycle, MemDone at cycle 2, MemRData=16'hBEEF, Stall high in cycles 0-1.
REQ-034 Write, MemAddr=16'h0012, MemWData=16'h1234, BusReady after 3 wait cycles -> BusWE is 1 and BusAddr/BusWData are held constant for 4 cycles, then MemDone, and MemRData is unchanged.
REQ-035 Read with BusReady never asserted, TIMEOUT=15 -> strobe drops after 15 WAIT cycles, MemErr=1, MemRData=16'hFFFF, one MemDone pulse.
REQ-036 MemRead and MemWrite both high -> no strobe, MemErr=1, MemDone at cycle 1.
REQ-037 rst_n driven low during WAIT of a read -> next cycle state is IDLE, BusRE=0, no MemDone, MemRData=0; a new read then completes normally.
REQ-038 BusReady coinciding with wait counter=TIMEOUT -> normal completion, MemErr stays 0.
